// File: rtl/id_ex_pipe_reg_if.sv
// Bundle of the ID-side inputs, EX-side outputs and hazard controls of the
// ID/EX pipeline register. The slave modport is the register's view; master
// is the driver's view (hazard unit / decode stage / execute stage).
interface id_ex_pipe_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
);
    logic              stall;
    logic              flush;

    logic              id_valid;
    logic [DATA_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_imm;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic              id_reg_write;
    logic              id_mem_to_reg;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_branch;
    logic              id_alu_src;
    logic              id_reg_dst;
    logic [1:0]        id_alu_op;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_pc4;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_to_reg;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_branch;
    logic              ex_alu_src;
    logic              ex_reg_dst;
    logic [1:0]        ex_alu_op;

    logic [15:0]       bubble_count;

    modport master (
        output stall, flush,
        output id_valid, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
        output id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
        output id_branch, id_alu_src, id_reg_dst, id_alu_op,
        input  ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
        input  ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
        input  ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op,
        input  bubble_count
    );

    modport slave (
        input  stall, flush,
        input  id_valid, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
        input  id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
        input  id_branch, id_alu_src, id_reg_dst, id_alu_op,
        output ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
        output ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
        output ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op,
        output bubble_count
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: one-cycle copy of decode results into execute,
// with stall (hold) and flush (bubble) support. Flush beats stall.
// Optional feature macro IDEX_BUBBLE_CNT_EN: 16-bit saturating count of
// loaded bubbles on bubble_count; when undefined bubble_count is 0.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic            clock,
    input  logic            reset_n,
    id_ex_pipe_reg_if.slave pipe
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              alu_src;
        logic              reg_dst;
        logic [1:0]        alu_op;
    } ex_bank_t;

    ex_bank_t ex_q, ex_d;

    // Mode select: flush loads an all-zero bubble, stall holds, else capture.
    always_comb begin
        ex_d = ex_q;
        if (pipe.flush) begin
            ex_d = '0;
        end else if (!pipe.stall) begin
            ex_d.valid      = pipe.id_valid;
            ex_d.pc4        = pipe.id_pc4;
            ex_d.rd1        = pipe.id_rd1;
            ex_d.rd2        = pipe.id_rd2;
            ex_d.imm        = pipe.id_imm;
            ex_d.rs         = pipe.id_rs;
            ex_d.rt         = pipe.id_rt;
            ex_d.rd         = pipe.id_rd;
            ex_d.reg_write  = pipe.id_reg_write;
            ex_d.mem_to_reg = pipe.id_mem_to_reg;
            ex_d.mem_read   = pipe.id_mem_read;
            ex_d.mem_write  = pipe.id_mem_write;
            ex_d.branch     = pipe.id_branch;
            ex_d.alu_src    = pipe.id_alu_src;
            ex_d.reg_dst    = pipe.id_reg_dst;
            ex_d.alu_op     = pipe.id_alu_op;
            // A non-valid slot must never cause side effects downstream.
            if (!pipe.id_valid) begin
                ex_d.reg_write  = 1'b0;
                ex_d.mem_to_reg = 1'b0;
                ex_d.mem_read   = 1'b0;
                ex_d.mem_write  = 1'b0;
                ex_d.branch     = 1'b0;
                ex_d.alu_src    = 1'b0;
                ex_d.reg_dst    = 1'b0;
                ex_d.alu_op     = 2'b00;
            end
        end
    end

    // Register bank, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign pipe.ex_valid      = ex_q.valid;
    assign pipe.ex_pc4        = ex_q.pc4;
    assign pipe.ex_rd1        = ex_q.rd1;
    assign pipe.ex_rd2        = ex_q.rd2;
    assign pipe.ex_imm        = ex_q.imm;
    assign pipe.ex_rs         = ex_q.rs;
    assign pipe.ex_rt         = ex_q.rt;
    assign pipe.ex_rd         = ex_q.rd;
    assign pipe.ex_reg_write  = ex_q.reg_write;
    assign pipe.ex_mem_to_reg = ex_q.mem_to_reg;
    assign pipe.ex_mem_read   = ex_q.mem_read;
    assign pipe.ex_mem_write  = ex_q.mem_write;
    assign pipe.ex_branch     = ex_q.branch;
    assign pipe.ex_alu_src    = ex_q.alu_src;
    assign pipe.ex_reg_dst    = ex_q.reg_dst;
    assign pipe.ex_alu_op     = ex_q.alu_op;

`ifdef IDEX_BUBBLE_CNT_EN
    logic        bubble_load;
    logic [15:0] bcnt_q, bcnt_d;

    // A bubble enters EX on flush, or on a normal capture of a non-valid slot.
    assign bubble_load = pipe.flush | (~pipe.stall & ~pipe.id_valid);

    // Saturating increment.
    always_comb begin
        bcnt_d = bcnt_q;
        if (bubble_load && (bcnt_q != 16'hFFFF)) begin
            bcnt_d = bcnt_q + 16'd1;
        end
    end

    // Counter state, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bcnt_q <= 16'h0000;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    assign pipe.bubble_count = bcnt_q;
`else
    assign pipe.bubble_count = 16'h0000;
`endif

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register of the pipelined MIPS datapath. It captures the decode-stage results (register-file read data, the 32-bit sign-extended immediate, register specifiers, PC+4 and decoded control) on each clock edge and presents them to the execute stage. It sits directly downstream of the sign extender and register file and upstream of the ALU, ALU-source mux and forwarding logic. It supports hold (stall) and bubble insertion (flush) for hazard handling.

## Interface
Parameters:
- DATA_W, 32, width of data, PC and immediate fields.
- REG_W, 5, width of register specifiers.

Ports:
- clock  input  1  rising-edge clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold current contents (EX not ready to accept).
- flush  input  1  load a bubble instead of the ID values.
- id_valid  input  1  ID stage holds a real instruction.
- id_pc4  input  DATA_W  PC+4 of the ID instruction.
- id_rd1 / id_rd2  input  DATA_W  register-file read data for rs / rt.
- id_imm  input  DATA_W  sign-extended immediate from the sign extender.
- id_rs / id_rt / id_rd  input  REG_W  register specifiers.
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst  input  1 each  decoded control.
- id_alu_op  input  2  ALU operation class.
- ex_*  output  matching widths  registered copy of every id_* input above (ex_valid, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_reg_write ... ex_alu_op).
- bubble_count  output  16  bubble statistics (see Configuration).

## Operation
- Three update modes per clock edge, priority high to low:
  - flush=1: load bubble — ex_valid=0, all control outputs 0, all data/specifier outputs 0. Flush overrides stall.
  - stall=1 (flush=0): all ex_* outputs keep their value.
  - otherwise: capture all id_* inputs unchanged.
- id_valid=0 captured normally: ex_valid=0 and control outputs forced to 0 (data fields captured as-is); a non-valid instruction never asserts ex_reg_write, ex_mem_read, ex_mem_write or ex_branch.
- No arithmetic; id_imm passes through bit-exact (no re-extension, no shift).
- Internal state: one register bank; no FSM beyond the mode select above.

## Timing
- Latency: exactly 1 cycle from id_* to ex_*.
- stall and flush are sampled at the rising edge; effect visible after that edge.
- Simultaneous stall and flush: bubble loaded (flush wins).
- Consecutive stalls: contents held indefinitely, no decay.
- Reset (reset_n=0, any time, asynchronous): every ex_* output 0, bubble_count 0, immediately on assertion; mid-stall or mid-flush the pending operation is discarded. First capture occurs on the first rising edge with reset_n=1.

## Configuration
- Macro IDEX_BUBBLE_CNT_EN.
- Defined: 16-bit saturating counter, incremented on every edge where a bubble is loaded (flush=1, or capture with id_valid=0); stalls do not count; saturates at 16'hFFFF; cleared only by reset; driven on bubble_count.
- Not defined: counter logic absent, bubble_count tied to 16'h0000; all other behaviour identical.

## Test plan
- Reset: assert reset_n=0 mid-cycle with registers loaded -> all ex_* and bubble_count read 0 without a clock edge.
- Pass-through: id_imm=32'hFFFF_FF80, id_rd1=32'h0000_1234, id_rt=5'd9, id_reg_write=1, id_valid=1 -> next cycle ex_imm=32'hFFFF_FF80, ex_rd1=32'h0000_1234, ex_rt=9, ex_reg_write=1.
- Stall: load instruction A, then stall=1 for 3 cycles with different id_* values -> ex_* stays A for all 3 cycles, updates to new input on first edge after stall=0.
- Flush vs stall: stall=1 and flush=1 together with id_mem_write=1 -> ex_valid=0, ex_mem_write=0, ex_imm=0; with macro defined bubble_count increments by 1.
- Invalid capture: id_valid=0, id_mem_read=1, id_rd2=32'hDEAD_BEEF -> ex_mem_read=0, ex_valid=0, ex_rd2=32'hDEAD_BEEF.
- Counter saturation (macro defined): force 65,540 flushes -> bubble_count stops at 16'hFFFF; macro undefined -> bubble_count stays 0.
